writeback_unit: RTL and testbench

- Parametrised successor of the single-issue write stage.
- Commits one instruction's results per `enable` pulse: register-file write (int/float), PC redirect, and UART output.
- UART writes go into an internal FIFO drained by a small send FSM, so the core is released (`done`) without waiting for `uart_wdone` unless the FIFO is full.
- Sits between the execute/memory stage and the register files, PC register and UART transmitter.

---
 rtl/writeback_unit.sv | 189 ++++++++++++++++++
 tb/tb_writeback_unit.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit
// Commits one instruction's results per enable pulse. A commit can write the
// integer or float register file, redirect the PC, and/or queue a UART payload.
// UART payloads go through a small FIFO that a send FSM drains, so the core is
// released without waiting for the transmitter unless the FIFO is full.
//
// Optional feature: define WB_STALL_CNT_EN to add the 32-bit stall_cycles
// output. It counts the cycles in which a UART push is pending against a full
// FIFO, and saturates at all-ones.
//
// Ports:
//   clk, rstn      clock, synchronous active-low reset
//   enable         one-cycle commit request (ignored while a commit is unfinished)
//   wselector      [3]=uart, [2]=pc write, [1]=reg write, [0]=float RF select
//   pc, data, rd   next PC, result/UART payload, destination register
//   done           one-cycle commit-complete pulse (held high during reset)
//   pcenable       PC write strobe, with next_pc
//   wenable        RF write strobe, with fmode, wreg and wdata
//   uart_wenable   one-cycle send request, with uart_wdata
//   uart_wdone     transmitter finished the previous send
//   uart_level     FIFO occupancy
//   stall_cycles   (WB_STALL_CNT_EN only) full-FIFO stall cycle count
module writeback_unit #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int UART_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          enable,
    input  logic [3:0]                    wselector,
    input  logic [XLEN-1:0]               pc,
    input  logic [XLEN-1:0]               data,
    input  logic [REG_AW-1:0]             rd,
    output logic                          done,
    output logic                          pcenable,
    output logic [XLEN-1:0]               next_pc,
    output logic                          wenable,
    output logic                          fmode,
    output logic [REG_AW-1:0]             wreg,
    output logic [XLEN-1:0]               wdata,
    output logic                          uart_wenable,
    output logic [XLEN-1:0]               uart_wdata,
    input  logic                          uart_wdone,
    output logic [$clog2(UART_DEPTH):0]   uart_level
`ifdef WB_STALL_CNT_EN
    ,
    output logic [31:0]                   stall_cycles
`endif
);

    localparam int PTRW = $clog2(UART_DEPTH);
    localparam int LVLW = PTRW + 1;
    localparam logic [LVLW-1:0] DEPTH_L = LVLW'(UART_DEPTH);

    typedef enum logic {
        S_IDLE,
        S_WAIT
    } send_state_t;

    send_state_t     state, state_nxt;

    logic            busy;
    logic            pending;
    logic [XLEN-1:0] pend_data;
    logic [XLEN-1:0] mem [UART_DEPTH];
    logic [PTRW-1:0] wr_ptr;
    logic [PTRW-1:0] rd_ptr;
    logic            accept;
    logic            push;
    logic            pop;
    logic            full;

    // Occupancy is judged on the registered level only, so a pop in the same
    // cycle does not make room for a push until the following cycle.
    assign full   = (uart_level == DEPTH_L);
    assign accept = enable && !busy;
    assign push   = pending && !full;
    assign pop    = (state == S_IDLE) && (uart_level != '0);

    // Commit sequencing. busy covers the window between an accepted commit and
    // its done pulse; commits with no side effects finish immediately.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            done      <= 1'b1;
            pcenable  <= 1'b0;
            wenable   <= 1'b0;
            next_pc   <= '0;
            wreg      <= '0;
            wdata     <= '0;
            fmode     <= 1'b0;
            busy      <= 1'b0;
            pending   <= 1'b0;
            pend_data <= '0;
        end else begin
            done     <= 1'b0;
            pcenable <= 1'b0;
            wenable  <= 1'b0;
            if (accept) begin
                if (wselector[2]) begin
                    pcenable <= 1'b1;
                    next_pc  <= pc;
                end
                if (wselector[1]) begin
                    wenable <= 1'b1;
                    wreg    <= rd;
                    wdata   <= data;
                    fmode   <= wselector[0];
                end
                if (wselector[3]) begin
                    pending   <= 1'b1;
                    pend_data <= data;
                end
                if (wselector[3:1] == 3'b000) begin
                    done <= 1'b1;
                end else begin
                    busy <= 1'b1;
                end
            end else if (busy && (!pending || push)) begin
                busy    <= 1'b0;
                pending <= 1'b0;
                done    <= 1'b1;
            end
        end
    end

    // FIFO storage has no reset; only the pointers and level define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= pend_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            uart_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   uart_level <= uart_level + 1'b1;
                2'b01:   uart_level <= uart_level - 1'b1;
                default: uart_level <= uart_level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state        <= S_IDLE;
            uart_wenable <= 1'b0;
            uart_wdata   <= '0;
        end else begin
            state        <= state_nxt;
            uart_wenable <= pop;
            if (pop) begin
                uart_wdata <= mem[rd_ptr];
            end
        end
    end

    // uart_wdone only matters while a send is outstanding.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (uart_level != '0) state_nxt = S_WAIT;
            S_WAIT:  if (uart_wdone) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

`ifdef WB_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stall_cycles <= '0;
        end else if (pending && full && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit
// Directed and randomized commits against writeback_unit. The stimulus side
// pushes every expected register write, PC write and UART send into queues;
// a separate monitor pops and compares whenever the DUT raises a strobe.
// A responder process plays the UART transmitter.
module tb_writeback_unit;

    logic        clk;
    logic        rstn;
    logic        enable;
    logic [3:0]  wselector;
    logic [31:0] pc;
    logic [31:0] data;
    logic [4:0]  rd;
    logic        done;
    logic        pcenable;
    logic [31:0] next_pc;
    logic        wenable;
    logic        fmode;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        uart_wenable;
    logic [31:0] uart_wdata;
    logic        uart_wdone;
    logic [2:0]  uart_level;
`ifdef WB_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    int n_cmp;
    int n_fail;

    logic [37:0] exp_reg[$];
    logic [31:0] exp_pc[$];
    logic [31:0] exp_uart[$];

    bit uart_hold;
    int uart_delay;

    writeback_unit dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .wselector    (wselector),
        .pc           (pc),
        .data         (data),
        .rd           (rd),
        .done         (done),
        .pcenable     (pcenable),
        .next_pc      (next_pc),
        .wenable      (wenable),
        .fmode        (fmode),
        .wreg         (wreg),
        .wdata        (wdata),
        .uart_wenable (uart_wenable),
        .uart_wdata   (uart_wdata),
        .uart_wdone   (uart_wdone),
        .uart_level   (uart_level)
`ifdef WB_STALL_CNT_EN
        ,
        .stall_cycles (stall_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        n_cmp++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Drives one commit at a negedge, records the expected effects, and
    // returns at the negedge of T+1. With linger, enable stays high for one
    // more cycle carrying a PC write that must be ignored.
    task automatic applyStimulus(input logic [3:0] wsel, input logic [31:0] pcv,
                                 input logic [31:0] dv, input logic [4:0] rdv,
                                 input bit linger);
        enable    = 1'b1;
        wselector = wsel;
        pc        = pcv;
        data      = dv;
        rd        = rdv;
        if (wsel[2]) exp_pc.push_back(pcv);
        if (wsel[1]) exp_reg.push_back({wsel[0], rdv, dv});
        if (wsel[3]) exp_uart.push_back(dv);
        @(posedge clk);
        @(negedge clk);
        if (linger && (wsel[3:1] != 3'b000)) begin
            wselector = 4'b0100;
            pc        = $urandom;
        end else begin
            enable = 1'b0;
        end
    endtask

    // Counts cycles after the commit until done; lat = -1 if the bound expires.
    task automatic waitDone(input int bound, output int lat);
        lat = 1;
        while (!done && lat < bound) begin
            @(negedge clk);
            enable = 1'b0;
            lat++;
        end
        enable = 1'b0;
        if (!done) lat = -1;
    endtask

    task automatic doReset(input int cycles);
        rstn   = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("reset_done", done, 1);
            checkOutput("reset_strobes", {pcenable, wenable, uart_wenable}, 0);
            checkOutput("reset_level", uart_level, 0);
            checkOutput("reset_data", {next_pc, wreg, wdata, uart_wdata, fmode}, 0);
        end
        @(negedge clk);
        rstn = 1'b1;
        exp_reg.delete();
        exp_pc.delete();
        exp_uart.delete();
    endtask

    task automatic waitDrain(input int bound);
        int k;
        k = 0;
        while ((exp_uart.size() != 0 || uart_level != 0) && k < bound) begin
            @(negedge clk);
            k++;
        end
        repeat (6) @(negedge clk);
        checkOutput("drain_queue_empty", exp_uart.size(), 0);
        checkOutput("drain_level", uart_level, 0);
    endtask

    // Monitor: pops the expected value for every strobe the DUT raises.
    initial begin
        logic [37:0] er;
        logic [31:0] ev;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (wenable) begin
                    checkOutput("rf_write_expected", wenable, exp_reg.size() != 0);
                    if (exp_reg.size() != 0) begin
                        er = exp_reg.pop_front();
                        checkOutput("rf_write", {fmode, wreg, wdata}, er);
                    end
                end
                if (pcenable) begin
                    checkOutput("pc_write_expected", pcenable, exp_pc.size() != 0);
                    if (exp_pc.size() != 0) begin
                        ev = exp_pc.pop_front();
                        checkOutput("pc_write", next_pc, ev);
                    end
                end
                if (uart_wenable) begin
                    checkOutput("uart_send_expected", uart_wenable, exp_uart.size() != 0);
                    if (exp_uart.size() != 0) begin
                        ev = exp_uart.pop_front();
                        checkOutput("uart_send", uart_wdata, ev);
                    end
                end
            end
        end
    end

    // UART responder: acknowledges each send after uart_delay cycles unless held.
    initial begin
        bit resp_busy;
        int resp_cnt;
        resp_busy  = 1'b0;
        resp_cnt   = 0;
        uart_wdone = 1'b0;
        forever begin
            @(negedge clk);
            uart_wdone = 1'b0;
            if (!rstn) begin
                resp_busy = 1'b0;
            end else if (uart_wenable) begin
                resp_busy = 1'b1;
                resp_cnt  = uart_delay;
            end else if (resp_busy && !uart_hold) begin
                if (resp_cnt == 0) begin
                    uart_wdone = 1'b1;
                    resp_busy  = 1'b0;
                end else begin
                    resp_cnt--;
                end
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int lat;
        int k;
        logic [3:0] ws;
        bit lg;

        n_cmp      = 0;
        n_fail     = 0;
        uart_hold  = 1'b0;
        uart_delay = 0;
        enable     = 1'b0;
        wselector  = '0;
        pc         = '0;
        data       = '0;
        rd         = '0;
        rstn       = 1'b0;

        doReset(2);

        // Integer/float register write
        applyStimulus(4'b0011, 32'h0, 32'hDEADBEEF, 5'd7, 1'b0);
        waitDone(16, lat);
        checkOutput("rf_done_latency", lat, 2);

        // PC redirect
        applyStimulus(4'b0100, 32'h100, 32'h0, 5'd0, 1'b0);
        waitDone(16, lat);
        checkOutput("pc_done_latency", lat, 2);

        // Commits with no side effects complete at T+1
        applyStimulus(4'b0000, 32'h0, 32'h1234, 5'd3, 1'b0);
        waitDone(16, lat);
        checkOutput("nop_done_latency", lat, 1);
        applyStimulus(4'b0001, 32'h0, 32'h5678, 5'd4, 1'b0);
        waitDone(16, lat);
        checkOutput("fmode_only_done_latency", lat, 1);

        // enable held into the busy cycle must be ignored
        applyStimulus(4'b0010, 32'h0, 32'hCAFE0001, 5'd31, 1'b1);
        waitDone(16, lat);
        checkOutput("linger_done_latency", lat, 2);

        // UART commit on an empty FIFO
        applyStimulus(4'b1000, 32'h0, 32'hA5A5_5A5A, 5'd0, 1'b0);
        k = 1;
        while (!uart_wenable && k < 10) begin
            @(negedge clk);
            k++;
            if (k == 2) checkOutput("uart_done_t2", done, 1);
        end
        checkOutput("uart_send_latency", k, 3);
        repeat (3) @(negedge clk);
        checkOutput("uart_level_after_send", uart_level, 0);

        // Fill the FIFO with the transmitter stalled: the first payload is
        // popped into flight, the next four fill the FIFO, the sixth stalls.
        uart_hold = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(4'b1000, 32'h0, 32'(i), 5'd0, 1'b0);
            waitDone(16, lat);
            checkOutput("fill_done_latency", lat, 2);
        end
        applyStimulus(4'b1000, 32'h0, 32'd6, 5'd0, 1'b0);
        waitDone(12, lat);
        checkOutput("full_withholds_done", lat, -1);
        checkOutput("full_level", uart_level, 4);
`ifdef WB_STALL_CNT_EN
        checkOutput("stall_count_nonzero", stall_cycles != 0, 1);
`endif
        uart_hold = 1'b0;
        waitDone(12, lat);
        checkOutput("stall_release_done", lat > 0, 1);
        waitDrain(200);

        // Reset while a send is in flight with two entries queued
        uart_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b1000, 32'h0, 32'h10 + 32'(i), 5'd0, 1'b0);
            waitDone(16, lat);
            checkOutput("pre_reset_done_latency", lat, 2);
        end
        repeat (2) @(negedge clk);
        checkOutput("pre_reset_level", uart_level, 2);
        doReset(2);
        uart_hold = 1'b0;
        repeat (20) @(negedge clk);
        checkOutput("post_reset_level", uart_level, 0);

        // Randomized commits with a variable-speed transmitter
        for (int n = 0; n < 200; n++) begin
            ws         = 4'($urandom);
            lg         = ($urandom_range(0, 3) == 0);
            uart_delay = $urandom_range(0, 3);
            applyStimulus(ws, $urandom, $urandom, 5'($urandom), lg);
            waitDone(64, lat);
            if (ws[3:1] == 3'b000)
                checkOutput("rand_done_latency_nop", lat, 1);
            else if (!ws[3])
                checkOutput("rand_done_latency_rf_pc", lat, 2);
            else
                checkOutput("rand_done_latency_uart_min2", lat >= 2, 1);
            if ($urandom_range(0, 4) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
        end
        waitDrain(400);
        checkOutput("final_rf_queue_empty", exp_reg.size(), 0);
        checkOutput("final_pc_queue_empty", exp_pc.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
